srl_fifo_buf: RTL and testbench

- Synchronous first-word-fall-through FIFO built from an addressable shift-register chain (SRL-style), width/depth parameterised.
- Used as the stimulus/staging buffer in front of the tanimoto accelerator's AXI-Stream data input (q→tdata, ~empty→tvalid, rd←tready), and as a generic elastic buffer elsewhere.

---
 rtl/srl_fifo_buf_pkg.sv | 18 +
 rtl/srl_fifo_buf_if.sv | 37 +++
 rtl/srl_fifo_shreg.sv | 42 ++++
 rtl/srl_fifo_buf.sv | 87 ++++++++
 tb/tb_srl_fifo_buf.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/srl_fifo_buf_pkg.sv
// Shared definitions for the SRL-style first-word-fall-through FIFO.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default word width and entry count
//   cnt_width()  : width of an occupancy counter that spans 0..depth
//   addr_width() : width of an index into 0..depth-1 (at least 1 bit)
package srl_fifo_pkg;

    localparam int DEFAULT_WIDTH = 128;
    localparam int DEFAULT_DEPTH = 256;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/srl_fifo_buf_if.sv
// Handshake/data bundle between a FIFO user and srl_fifo_buf.
//   wr, d      : write request and write data (user -> FIFO)
//   rd         : read request / consume current head (user -> FIFO)
//   q          : head (oldest) entry, zero when empty (FIFO -> user)
//   full/empty : occupancy flags (FIFO -> user)
//   count      : occupancy 0..DEPTH (FIFO -> user)
//   overflow/underflow : sticky error flags (FIFO -> user)
// master = FIFO user side, slave = FIFO side.
interface srl_fifo_buf_if
    import srl_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic             wr;
    logic [WIDTH-1:0] d;
    logic             full;
    logic             rd;
    logic [WIDTH-1:0] q;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr, d, rd,
        input  full, q, empty, count, overflow, underflow
    );

    modport slave (
        input  wr, d, rd,
        output full, q, empty, count, overflow, underflow
    );

endinterface

// File: rtl/srl_fifo_shreg.sv
// Storage for srl_fifo_buf: a shift chain with an addressed read mux.
// No reset on the storage so it maps onto shift-register primitives.
//   clk      : clock
//   shift_en : push d into entry 0 and shift the whole chain by one
//   d        : data pushed into entry 0
//   rd_addr  : entry presented on q (oldest entry sits at occupancy-1)
//   rd_en    : when low, q is forced to zero
//   q        : selected entry
module srl_fifo_shreg #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    rd_addr,
    input  logic             rd_en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] srl [DEPTH];

    always_ff @(posedge clk) begin
        if (shift_en) begin
            srl[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                srl[i] <= srl[i-1];
            end
        end
    end

    // Stale entries beyond the occupancy must never leak out, so an empty
    // FIFO shows zero instead of whatever the chain happens to hold.
    always_comb begin
        q = '0;
        if (rd_en) begin
            q = srl[rd_addr];
        end
    end

endmodule

// File: rtl/srl_fifo_buf.sv
// Synchronous first-word-fall-through FIFO on an SRL-style shift chain.
// New words enter at entry 0 and push the chain; the head is read from
// entry count-1, so a read only decrements the counter.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset (counter and flags only)
//   bus  : srl_fifo_buf_if.slave (wr, d, rd in; q, full, empty, count,
//          overflow, underflow out)
// Build option: define SRL_FIFO_ERR_FLAGS_EN to get sticky overflow /
// underflow flags; otherwise both outputs are tied to zero.
module srl_fifo_buf
    import srl_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic           clk,
    input  logic           rstn,
    srl_fifo_buf_if.slave  bus
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int AW    = addr_width(DEPTH);

    logic [CNT_W-1:0] count_r;
    logic             empty_w;
    logic             full_w;
    logic             rd_acc;
    logic             wr_acc;
    logic [AW-1:0]    rd_addr;

    assign empty_w = (count_r == '0);
    assign full_w  = (count_r == CNT_W'(DEPTH));

    // A write into a full FIFO is still accepted when the same cycle's read
    // frees the oldest slot: the shift pushes that entry off the chain end.
    assign rd_acc  = bus.rd && !empty_w;
    assign wr_acc  = bus.wr && (!full_w || rd_acc);

    assign rd_addr = AW'(count_r - CNT_W'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_r <= '0;
        end else if (wr_acc != rd_acc) begin
            count_r <= wr_acc ? count_r + CNT_W'(1) : count_r - CNT_W'(1);
        end
    end

`ifdef SRL_FIFO_ERR_FLAGS_EN
    logic overflow_r;
    logic underflow_r;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (bus.wr && full_w && !rd_acc) overflow_r  <= 1'b1;
            if (bus.rd && empty_w)           underflow_r <= 1'b1;
        end
    end

    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    srl_fifo_shreg #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_shreg (
        .clk      (clk),
        .shift_en (wr_acc),
        .d        (bus.d),
        .rd_addr  (rd_addr),
        .rd_en    (!empty_w),
        .q        (bus.q)
    );

    assign bus.empty = empty_w;
    assign bus.full  = full_w;
    assign bus.count = count_r;

endmodule

// File: tb/tb_srl_fifo_buf.sv
// Self-checking bench for srl_fifo_buf (WIDTH=128, DEPTH=256).
// A queue-based reference model tracks the FIFO contents and sticky flags;
// one compare process checks every DUT output against it on each falling
// edge, and directed sections add literal expectations.
module tb_srl_fifo_buf;

    localparam int WIDTH = 128;
    localparam int DEPTH = 256;
    localparam int CNT_W = 9;

`ifdef SRL_FIFO_ERR_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    always #5 clk = ~clk;

    srl_fifo_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bif ();

    srl_fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bif)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mq [$];
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;

    task automatic chk_q(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_n(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain queue, oldest word at the front.
    always @(posedge clk or negedge rstn) begin : model
        bit racc;
        bit wacc;
        if (!rstn) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            racc = bif.rd && (mq.size() > 0);
            wacc = bif.wr && ((mq.size() < DEPTH) || racc);
            if (bif.wr && (mq.size() == DEPTH) && !racc) m_ovf = 1'b1;
            if (bif.rd && (mq.size() == 0))              m_unf = 1'b1;
            if (racc) void'(mq.pop_front());
            if (wacc) mq.push_back(bif.d);
        end
    end

    always @(negedge clk) begin : compare
        logic [WIDTH-1:0] exp_q;
        exp_q = (mq.size() > 0) ? mq[0] : '0;
        chk_q("q", bif.q, exp_q);
        chk_n("count", int'(bif.count), mq.size());
        chk_n("empty", int'(bif.empty), int'(mq.size() == 0));
        chk_n("full", int'(bif.full), int'(mq.size() == DEPTH));
        chk_n("overflow", int'(bif.overflow), int'(FLAGS_EN && m_ovf));
        chk_n("underflow", int'(bif.underflow), int'(FLAGS_EN && m_unf));
    end

    // Apply one cycle of inputs, return 1 time unit after the rising edge.
    task automatic cyc(input bit w, input bit r, input logic [WIDTH-1:0] dv);
        bif.wr = w;
        bif.rd = r;
        bif.d  = dv;
        @(posedge clk);
        #1;
        bif.wr = 1'b0;
        bif.rd = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin : stim
        logic [WIDTH-1:0] pat_a5;
        logic [WIDTH-1:0] pat_new;
        bit               w;
        bit               r;

        pat_a5  = {16{8'hA5}};
        pat_new = {32{4'h3}};
        bif.wr = 1'b0;
        bif.rd = 1'b0;
        bif.d  = '0;

        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_n("rst_count", int'(bif.count), 0);
        chk_n("rst_empty", int'(bif.empty), 1);
        chk_n("rst_full", int'(bif.full), 0);
        chk_q("rst_q", bif.q, '0);
        chk_n("rst_ovf", int'(bif.overflow), 0);
        chk_n("rst_unf", int'(bif.underflow), 0);
        rstn = 1'b1;
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        chk_n("idle_count", int'(bif.count), 0);
        chk_n("idle_empty", int'(bif.empty), 1);

        // First word falls through with no read.
        cyc(1'b1, 1'b0, pat_a5);
        chk_q("fwft_q", bif.q, pat_a5);
        chk_n("fwft_empty", int'(bif.empty), 0);
        cyc(1'b0, 1'b1, '0);
        chk_n("fwft_drain_empty", int'(bif.empty), 1);

        // Fill to DEPTH with d=i.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, WIDTH'(i));
        chk_n("fill_full", int'(bif.full), 1);
        chk_n("fill_count", int'(bif.count), DEPTH);

        // Write while full without read is dropped.
        cyc(1'b1, 1'b0, WIDTH'(32'hDEAD));
        chk_n("ovf_count", int'(bif.count), DEPTH);
        chk_q("ovf_head", bif.q, WIDTH'(0));
        chk_n("ovf_flag", int'(bif.overflow), int'(FLAGS_EN));

        // Read and write while full: oldest leaves, new word enters.
        cyc(1'b1, 1'b1, WIDTH'(1000));
        chk_n("full_rw_count", int'(bif.count), DEPTH);
        chk_q("full_rw_head", bif.q, WIDTH'(1));

        for (int i = 1; i < DEPTH; i++) begin
            chk_q("drain_seq", bif.q, WIDTH'(i));
            cyc(1'b0, 1'b1, '0);
        end
        chk_q("drain_last", bif.q, WIDTH'(1000));
        chk_n("drain_last_count", int'(bif.count), 1);
        cyc(1'b0, 1'b1, '0);
        chk_n("drained_empty", int'(bif.empty), 1);

        // Read and write while empty: only the write takes effect.
        cyc(1'b1, 1'b1, WIDTH'(32'h77));
        chk_n("empty_rw_count", int'(bif.count), 1);
        chk_q("empty_rw_q", bif.q, WIDTH'(32'h77));
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b1, '0);
        chk_n("unf_flag", int'(bif.underflow), int'(FLAGS_EN));
        chk_n("unf_count", int'(bif.count), 0);

        // Concurrent read/write at count 5.
        repeat (5) cyc(1'b1, 1'b0, rnd_word());
        repeat (3) cyc(1'b1, 1'b1, rnd_word());
        chk_n("mid_rw_count", int'(bif.count), 5);
        repeat (5) cyc(1'b0, 1'b1, '0);

        // Randomised traffic in phases: filling, draining, 1-in-4 bursts, mixed.
        for (int j = 0; j < 4000; j++) begin
            if (j < 1000) begin
                w = ($urandom_range(0, 99) < 70);
                r = ($urandom_range(0, 99) < 30);
            end else if (j < 2000) begin
                w = ($urandom_range(0, 99) < 30);
                r = ($urandom_range(0, 99) < 70);
            end else if (j < 3000) begin
                w = ((j % 4) == 0);
                r = ($urandom_range(0, 99) < 40);
            end else begin
                w = ($urandom_range(0, 1) == 1);
                r = ($urandom_range(0, 1) == 1);
            end
            cyc(w, r, rnd_word());
        end

        // Bring occupancy to 100, then pulse reset between clock edges.
        while (mq.size() > 100) cyc(1'b0, 1'b1, '0);
        while (mq.size() < 100) cyc(1'b1, 1'b0, rnd_word());
        chk_n("pre_rst_count", int'(bif.count), 100);
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk_n("async_count", int'(bif.count), 0);
        chk_n("async_empty", int'(bif.empty), 1);
        chk_q("async_q", bif.q, '0);
        chk_n("async_ovf", int'(bif.overflow), 0);
        chk_n("async_unf", int'(bif.underflow), 0);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, pat_new);
        chk_q("post_rst_q", bif.q, pat_new);
        chk_n("post_rst_count", int'(bif.count), 1);
        cyc(1'b0, 1'b1, '0);
        chk_n("post_rst_empty", int'(bif.empty), 1);

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
